// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for mul_arbiter: RV64M op encodings, FSM states,
// multiplier signedness codes and the op decoder.
package mul_arbiter_pkg;

    localparam logic [3:0] OP_MUL    = 4'b0000;
    localparam logic [3:0] OP_MULH   = 4'b0001;
    localparam logic [3:0] OP_MULHSU = 4'b0010;
    localparam logic [3:0] OP_MULHU  = 4'b0011;
    localparam logic [3:0] OP_MULW   = 4'b1000;

    // Bit 1 = multiplicand signed, bit 0 = multiplier signed.
    localparam logic [1:0] SGN_SS = 2'b11;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_UU = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_LO,
        SEL_HI,
        SEL_LO_W
    } res_sel_e;

    typedef struct packed {
        logic       legal;
        logic       w;
        logic [1:0] sgn;
        res_sel_e   sel;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [3:0] op);
        op_dec_t d;
        d.legal = 1'b1;
        d.w     = 1'b0;
        d.sgn   = SGN_SS;
        d.sel   = SEL_LO;
        case (op)
            OP_MUL: begin
                d.sgn = SGN_SS;
                d.sel = SEL_LO;
            end
            OP_MULH: begin
                d.sgn = SGN_SS;
                d.sel = SEL_HI;
            end
            OP_MULHSU: begin
                d.sgn = SGN_SU;
                d.sel = SEL_HI;
            end
            OP_MULHU: begin
                d.sgn = SGN_UU;
                d.sel = SEL_HI;
            end
            OP_MULW: begin
                d.sgn = SGN_SS;
                d.w   = 1'b1;
                d.sel = SEL_LO_W;
            end
            default: begin
                d.legal = 1'b0;
                d.sgn   = SGN_UU;
                d.sel   = SEL_LO;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mul_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr,
// wrapping to the lowest valid one below it.
import mul_arbiter_pkg::*;

module mul_rr_picker #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any
);

    logic [PW-1:0] hi_idx;
    logic [PW-1:0] lo_idx;
    logic          hi_any;
    logic          lo_any;

    // Scanning downward leaves the lowest matching index in each candidate.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = PW'(i);
                lo_any = 1'b1;
                if (PW'(i) >= rr_ptr) begin
                    hi_idx = PW'(i);
                    hi_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant     = '0;
        any       = hi_any | lo_any;
        grant_idx = hi_any ? hi_idx : lo_idx;
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates NREQ requesters onto one iterative multiplier and returns results.
// Optional single-entry result cache enabled by MUL_ARB_RESULT_CACHE_EN.
import mul_arbiter_pkg::*;

module mul_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [XLEN*NREQ-1:0] req_a,
    input  logic [XLEN*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]      req_flush,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_flush,
    output logic                 m_mulw,
    output logic [1:0]           m_signed,
    output logic [XLEN-1:0]      m_a,
    output logic [XLEN-1:0]      m_b,
    input  logic                 m_out_valid,
    input  logic [XLEN-1:0]      m_hi,
    input  logic [XLEN-1:0]      m_lo
);

    localparam int PW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]      sgn_q, sgn_d;
    logic            w_q, w_d;
    res_sel_e        sel_q, sel_d;
    logic            m_flush_q, m_flush_d;

    logic [3:0]      op_arr [NREQ];
    logic [XLEN-1:0] a_arr  [NREQ];
    logic [XLEN-1:0] b_arr  [NREQ];

    logic [NREQ-1:0] pick_grant;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    op_dec_t         win_dec;
    logic            cache_hit;
    logic [XLEN-1:0] cache_data;
    logic            flush_own;
    logic            wait_done;

    function automatic logic [XLEN-1:0] select_result(input res_sel_e sel,
                                                      input logic [XLEN-1:0] hi,
                                                      input logic [XLEN-1:0] lo);
        logic [XLEN-1:0] r;
        case (sel)
            SEL_HI:   r = hi;
            SEL_LO_W: r = {{(XLEN-32){lo[31]}}, lo[31:0]};
            default:  r = lo;
        endcase
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_arr[i] = req_op[4*i +: 4];
            a_arr[i]  = req_a[XLEN*i +: XLEN];
            b_arr[i]  = req_b[XLEN*i +: XLEN];
        end
    end

    mul_rr_picker #(
        .NREQ(NREQ),
        .PW  (PW)
    ) u_picker (
        .req_valid(req_valid),
        .rr_ptr   (rr_ptr_q),
        .grant    (pick_grant),
        .grant_idx(pick_idx),
        .any      (pick_any)
    );

    assign win_dec   = decode_op(op_arr[pick_idx]);
    assign flush_own = req_flush[owner_q];
    assign wait_done = (state_q == WAIT) && !flush_own && m_out_valid;

`ifdef MUL_ARB_RESULT_CACHE_EN
    logic            c_vld_q, c_vld_d;
    logic            c_w_q, c_w_d;
    logic [1:0]      c_sgn_q, c_sgn_d;
    logic [XLEN-1:0] c_a_q, c_a_d;
    logic [XLEN-1:0] c_b_q, c_b_d;
    logic [XLEN-1:0] c_hi_q, c_hi_d;
    logic [XLEN-1:0] c_lo_q, c_lo_d;

    // A MUL only needs lo, which is the same for every signedness when w=0.
    always_comb begin
        c_vld_d = c_vld_q;
        c_w_d   = c_w_q;
        c_sgn_d = c_sgn_q;
        c_a_d   = c_a_q;
        c_b_d   = c_b_q;
        c_hi_d  = c_hi_q;
        c_lo_d  = c_lo_q;
        if (wait_done) begin
            c_vld_d = 1'b1;
            c_w_d   = w_q;
            c_sgn_d = sgn_q;
            c_a_d   = a_q;
            c_b_d   = b_q;
            c_hi_d  = m_hi;
            c_lo_d  = m_lo;
        end
        cache_hit = c_vld_q && win_dec.legal
                    && (a_arr[pick_idx] == c_a_q) && (b_arr[pick_idx] == c_b_q)
                    && (win_dec.w == c_w_q)
                    && ((win_dec.sgn == c_sgn_q) || ((op_arr[pick_idx] == OP_MUL) && !c_w_q));
        cache_data = select_result(win_dec.sel, c_hi_q, c_lo_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld_q <= 1'b0;
            c_w_q   <= 1'b0;
            c_sgn_q <= '0;
            c_a_q   <= '0;
            c_b_q   <= '0;
            c_hi_q  <= '0;
            c_lo_q  <= '0;
        end else begin
            c_vld_q <= c_vld_d;
            c_w_q   <= c_w_d;
            c_sgn_q <= c_sgn_d;
            c_a_q   <= c_a_d;
            c_b_q   <= c_b_d;
            c_hi_q  <= c_hi_d;
            c_lo_q  <= c_lo_d;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    // Illegal ops and cache hits bypass the multiplier straight to RESP.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        sgn_d      = sgn_q;
        w_d        = w_q;
        sel_d      = sel_q;
        m_flush_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d  = pick_idx;
                    rr_ptr_d = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    a_d      = a_arr[pick_idx];
                    b_d      = b_arr[pick_idx];
                    sgn_d    = win_dec.sgn;
                    w_d      = win_dec.w;
                    sel_d    = win_dec.sel;
                    if (!win_dec.legal) begin
                        rsp_data_d = '0;
                        state_d    = RESP;
                    end else if (cache_hit) begin
                        rsp_data_d = cache_data;
                        state_d    = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (flush_own) begin
                    m_flush_d = 1'b1;
                    state_d   = IDLE;
                end else if (m_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush_own) begin
                    m_flush_d = 1'b1;
                    state_d   = IDLE;
                end else if (m_out_valid) begin
                    rsp_data_d = select_result(sel_q, m_hi, m_lo);
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (flush_own || rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            sgn_q      <= '0;
            w_q        <= 1'b0;
            sel_q      <= SEL_LO;
            m_flush_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            sgn_q      <= sgn_d;
            w_q        <= w_d;
            sel_q      <= sel_d;
            m_flush_q  <= m_flush_d;
        end
    end

    // Grant is gated by rst_n so no requester sees ready while held in reset.
    always_comb begin
        req_ready = ((state_q == IDLE) && rst_n) ? pick_grant : '0;
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign m_valid  = (state_q == ISSUE);
    assign m_flush  = m_flush_q;
    assign m_mulw   = w_q;
    assign m_signed = sgn_q;
    assign m_a      = a_q;
    assign m_b      = b_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural multiplier model and
// a spec-level result reference. Covers MUL_ARB_RESULT_CACHE_EN when defined.
`timescale 1ns/1ps

module tb_mul_arbiter;

    localparam int NREQ = 2;
    localparam int XLEN = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [4*NREQ-1:0]    req_op;
    logic [XLEN*NREQ-1:0] req_a;
    logic [XLEN*NREQ-1:0] req_b;
    logic [NREQ-1:0]      req_flush;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [XLEN-1:0]      rsp_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_flush;
    logic                 m_mulw;
    logic [1:0]           m_signed;
    logic [XLEN-1:0]      m_a;
    logic [XLEN-1:0]      m_b;
    logic                 m_out_valid;
    logic [XLEN-1:0]      m_hi;
    logic [XLEN-1:0]      m_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_flush  (req_flush),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_flush    (m_flush),
        .m_mulw     (m_mulw),
        .m_signed   (m_signed),
        .m_a        (m_a),
        .m_b        (m_b),
        .m_out_valid(m_out_valid),
        .m_hi       (m_hi),
        .m_lo       (m_lo)
    );

    // Reference: architectural RV64M result from op and operands.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] sa, sb, za, zb, p;
        logic [63:0]  t;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        za = {64'd0, a};
        zb = {64'd0, b};
        t  = a * b;
        p  = '0;
        case (op)
            4'b0000: return t;
            4'b0001: begin p = sa * sb; return p[127:64]; end
            4'b0010: begin p = sa * zb; return p[127:64]; end
            4'b0011: begin p = za * zb; return p[127:64]; end
            4'b1000: return {{32{t[31]}}, t[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [127:0] mult_model(input logic [63:0] a, input logic [63:0] b,
                                                input logic [1:0] sgn);
        logic [127:0] ea, eb;
        ea = sgn[1] ? {{64{a[63]}}, a} : {64'd0, a};
        eb = sgn[0] ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    // Multiplier model: accepts on valid&ready, answers after a latency,
    // keeps out_valid high until the next accept, drops work on flush.
    int            mlat_fixed = 0;
    bit            mready_force = 1'b0;
    logic [127:0]  mm_prod;
    int            mm_cnt;
    bit            mm_busy;
    int            mflush_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready     <= 1'b0;
            m_out_valid <= 1'b0;
            m_hi        <= '0;
            m_lo        <= '0;
            mm_busy     <= 1'b0;
            mm_cnt      <= 0;
            mm_prod     <= '0;
        end else begin
            m_ready <= mready_force || ($urandom_range(0, 3) != 0);
            if (m_flush) begin
                mm_busy     <= 1'b0;
                m_out_valid <= 1'b0;
            end else if (m_valid && m_ready) begin
                mm_prod     <= mult_model(m_a, m_b, m_signed);
                mm_cnt      <= (mlat_fixed > 0) ? mlat_fixed : int'($urandom_range(1, 4));
                mm_busy     <= 1'b1;
                m_out_valid <= 1'b0;
            end else if (mm_busy) begin
                if (mm_cnt <= 1) begin
                    m_hi        <= mm_prod[127:64];
                    m_lo        <= mm_prod[63:0];
                    m_out_valid <= 1'b1;
                    mm_busy     <= 1'b0;
                end else begin
                    mm_cnt <= mm_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_flush) mflush_cnt <= mflush_cnt + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out, got no event, required one", name);
    endtask

    task automatic drive_req(input int port, input logic [3:0] op, input logic [63:0] a,
                             input logic [63:0] b);
        req_valid[port]       = 1'b1;
        req_op[4*port +: 4]   = op;
        req_a[64*port +: 64]  = a;
        req_b[64*port +: 64]  = b;
    endtask

    // One full transaction on a port; reports data, multiplier usage and latency.
    task automatic apply_stimulus(input int port, input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] data,
                                  output bit saw_mv, output logic [1:0] sgn, output logic w,
                                  output int lat, output bit ok);
        int n;
        data = '0; saw_mv = 1'b0; sgn = '0; w = 1'b0; lat = 0; ok = 1'b0;
        @(negedge clk);
        drive_req(port, op, a, b);
        #1;
        n = 0;
        while (!req_ready[port] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready[port]) begin
            note_timeout("grant");
            req_valid[port] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[port] = 1'b0;
        #1;
        n = 1;
        while (!rsp_valid[port] && n < 200) begin
            if (m_valid) begin
                saw_mv = 1'b1;
                sgn    = m_signed;
                w      = m_mulw;
            end
            @(negedge clk); #1; n++;
        end
        if (!rsp_valid[port]) begin
            note_timeout("response");
            return;
        end
        lat  = n;
        data = rsp_data;
        ok   = 1'b1;
        rsp_ready[port] = 1'b1;
        @(negedge clk);
        rsp_ready[port] = 1'b0;
    endtask

    typedef struct {
        int         port;
        logic [3:0] op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic [1:0] exp_sgn;
        logic       exp_w;
        bit         legal;
    } vec_t;

    vec_t vecs[8];
    logic [3:0] op_pool[7];

    initial begin
        logic [63:0] d, d0;
        bit          smv, ok, stable;
        logic [1:0]  sg;
        logic        ww;
        int          lat, n, gp, prev, mf, rv, base;
        logic [3:0]  pop[2];
        logic [63:0] pa[2], pb[2];
        logic [63:0] exp_d;

        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        req_flush = '0; rsp_ready = '0;

        vecs[0] = '{0, 4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 2'b11, 1'b0, 1'b1};
        vecs[1] = '{1, 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1'b0, 1'b1};
        vecs[2] = '{1, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 1'b1};
        vecs[3] = '{0, 4'b1000, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2'b11, 1'b1, 1'b1};
        vecs[4] = '{0, 4'b1011, 64'd5, 64'd6, 64'd0, 2'b00, 1'b0, 1'b0};
        vecs[5] = '{1, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'b11, 1'b0, 1'b1};
        vecs[6] = '{1, 4'b1000, 64'h1_0000_0003, 64'd5, 64'hF, 2'b11, 1'b1, 1'b1};
        vecs[7] = '{0, 4'b1111, 64'h1234, 64'h5678, 64'd0, 2'b00, 1'b0, 1'b0};

        op_pool[0] = 4'b0000; op_pool[1] = 4'b0001; op_pool[2] = 4'b0010;
        op_pool[3] = 4'b0011; op_pool[4] = 4'b1000; op_pool[5] = 4'b0100;
        op_pool[6] = 4'b1001;

        // Reset state, with requests present to show grants stay low.
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_req_ready", 64'(req_ready), 64'd0);
        check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("reset_m_ctl", {60'd0, m_valid, m_flush, m_mulw, |m_signed}, 64'd0);
        check_output("reset_m_a", m_a, 64'd0);
        check_output("reset_m_b", m_b, 64'd0);
        check_output("reset_rsp_data", rsp_data, 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, d, smv, sg, ww, lat, ok);
            if (ok) begin
                check_output($sformatf("vec%0d_data", i), d, vecs[i].exp);
                if (vecs[i].legal)
                    check_output($sformatf("vec%0d_mctl", i), {60'd0, smv, sg, ww},
                                 {60'd0, 1'b1, vecs[i].exp_sgn, vecs[i].exp_w});
                else
                    check_output($sformatf("vec%0d_no_mvalid", i), 64'(smv), 64'd0);
            end
        end

        // Both ports always requesting: grants must alternate.
        for (int p = 0; p < 2; p++) begin
            pop[p] = (p == 0) ? 4'b0000 : 4'b0011;
            pa[p]  = {$urandom, $urandom};
            pb[p]  = {$urandom, $urandom};
        end
        @(negedge clk);
        for (int p = 0; p < 2; p++) drive_req(p, pop[p], pa[p], pb[p]);
        #1;
        prev = -1;
        for (int g = 0; g < 8; g++) begin
            n = 0;
            while (req_ready == '0 && n < 50) begin
                @(negedge clk); #1; n++;
            end
            if (req_ready == '0) begin
                note_timeout("rr_grant");
                break;
            end
            gp = req_ready[1] ? 1 : 0;
            if (prev >= 0) check_output("rr_alternate", 64'(gp), 64'(1 - prev));
            prev  = gp;
            exp_d = ref_result(pop[gp], pa[gp], pb[gp]);
            @(negedge clk);
            pa[gp] = {$urandom, $urandom};
            pb[gp] = {$urandom, $urandom};
            drive_req(gp, pop[gp], pa[gp], pb[gp]);
            #1;
            n = 0;
            while (!rsp_valid[gp] && n < 200) begin
                @(negedge clk); #1; n++;
            end
            if (!rsp_valid[gp]) begin
                note_timeout("rr_response");
                break;
            end
            if (g == 3) begin
                d0 = rsp_data;
                stable = 1'b1;
                repeat (5) begin
                    @(negedge clk); #1;
                    if (!rsp_valid[gp] || rsp_data !== d0) stable = 1'b0;
                end
                check_output("rsp_hold_stable", 64'(stable), 64'd1);
            end
            check_output("rr_data", rsp_data, exp_d);
            rsp_ready[gp] = 1'b1;
            @(negedge clk); #1;
            rsp_ready[gp] = 1'b0;
        end
        req_valid = '0;
        repeat (2) @(negedge clk);

        // Owner flush two cycles into WAIT.
        mready_force = 1'b1;
        mlat_fixed   = 10;
        repeat (2) @(negedge clk);
        drive_req(0, 4'b0000, 64'd9, 64'd9);
        #1;
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        req_flush[0] = 1'b1;
        @(negedge clk); #1;
        req_flush[0] = 1'b0;
        mf = 0; rv = 0;
        for (int c = 0; c < 15; c++) begin
            if (m_flush) mf++;
            if (rsp_valid != '0) rv++;
            @(negedge clk); #1;
        end
        check_output("flush_pulse_cycles", 64'(mf), 64'd1);
        check_output("flush_no_rsp", 64'(rv), 64'd0);
        apply_stimulus(0, 4'b0000, 64'd6, 64'd7, d, smv, sg, ww, lat, ok);
        if (ok) check_output("after_flush_data", d, 64'd42);

        // Non-owner flush during WAIT is ignored.
        base = mflush_cnt;
        fork
            apply_stimulus(0, 4'b0000, 64'd11, 64'd13, d, smv, sg, ww, lat, ok);
            begin
                repeat (5) @(negedge clk);
                #2 req_flush[1] = 1'b1;
                @(negedge clk);
                #2 req_flush[1] = 1'b0;
            end
        join
        if (ok) check_output("nonowner_flush_data", d, 64'd143);
        check_output("nonowner_no_mflush", 64'(mflush_cnt - base), 64'd0);

        // Reset in the middle of WAIT.
        drive_req(1, 4'b0011, 64'd5, 64'd5);
        #1;
        n = 0;
        while (!req_ready[1] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        base = mflush_cnt;
        rst_n = 1'b0;
        #1;
        check_output("midreset_outputs", {61'd0, m_valid, |rsp_valid, m_flush}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("midreset_no_mflush", 64'(mflush_cnt - base), 64'd0);
        apply_stimulus(1, 4'b0000, 64'd2, 64'd3, d, smv, sg, ww, lat, ok);
        if (ok) check_output("after_reset_data", d, 64'd6);

        // Randomised traffic against the reference.
        mready_force = 1'b0;
        mlat_fixed   = 0;
        for (int r = 0; r < 40; r++) begin
            logic [3:0]  rop;
            logic [63:0] ra, rb;
            int          rp;
            rp  = int'($urandom_range(0, 1));
            rop = op_pool[$urandom_range(0, 6)];
            ra  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 100)) : {$urandom, $urandom};
            rb  = ($urandom_range(0, 3) == 0) ? -64'($urandom_range(0, 100)) : {$urandom, $urandom};
            apply_stimulus(rp, rop, ra, rb, d, smv, sg, ww, lat, ok);
            if (ok) check_output($sformatf("rand%0d_op%h", r, rop), d, ref_result(rop, ra, rb));
        end

`ifdef MUL_ARB_RESULT_CACHE_EN
        apply_stimulus(0, 4'b0001, 64'h1_0000_0000, 64'h1_0000_0000, d, smv, sg, ww, lat, ok);
        if (ok) begin
            check_output("cache_fill_data", d, 64'd1);
            check_output("cache_fill_used_mul", 64'(smv), 64'd1);
        end
        apply_stimulus(1, 4'b0000, 64'h1_0000_0000, 64'h1_0000_0000, d, smv, sg, ww, lat, ok);
        if (ok) begin
            check_output("cache_hit_data", d, 64'd0);
            check_output("cache_hit_no_mvalid", 64'(smv), 64'd0);
            check_output("cache_hit_latency", 64'(lat), 64'd1);
        end
        apply_stimulus(0, 4'b0011, 64'h1_0000_0000, 64'h1_0000_0000, d, smv, sg, ww, lat, ok);
        if (ok) begin
            check_output("cache_miss_sgn_data", d, 64'd1);
            check_output("cache_miss_sgn_used_mul", 64'(smv), 64'd1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
